// File: rtl/pc_sequencer.sv
// Program-counter / fetch-address generator for the 6502-style core.
// Latency: vector load 2 cycles; branch 1 cycle, 2 on a page cross with PAGE_CROSS_PENALTY_EN.
// Backpressure: none; FIX stalls fetch and ignores requests, so vec_req must be held until RUN.
//
// Optional feature macro: PAGE_CROSS_PENALTY_EN
//   defined   - page-crossing branches take a second fix-up cycle (FIX, stall = 1)
//   undefined - page-crossing branches complete in one cycle, stall tied low

module pc_sequencer #(
    parameter logic [15:0] RESET_VEC = 16'hFFFC,
    parameter logic [15:0] NMI_VEC   = 16'hFFFA,
    parameter logic [15:0] IRQ_VEC   = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch,
    input  logic        pc_inc,
    input  logic        vec_req,
    input  logic [1:0]  vec_sel,
    input  logic [7:0]  data_bus,
    output logic [15:0] addr_bus,
    output logic [15:0] pc,
    output logic        pc_valid,
    output logic        vec_lo,
    output logic        stall
);

    typedef enum logic [1:0] {
        ST_VEC_LO = 2'd0,
        ST_VEC_HI = 2'd1,
        ST_RUN    = 2'd2,
        ST_FIX    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] vec_base_q, vec_base_d;
`ifdef PAGE_CROSS_PENALTY_EN
    logic [7:0]  tgt_hi_q, tgt_hi_d;
`endif

    // Branch target: offset is relative to the already-advanced PC, modulo 2^16.
    logic [15:0] offset_sx;
    logic [15:0] target;
    logic        page_cross;
    logic [15:0] sel_vec;

    // Sign-extend the branch offset and compute the target and page-cross flag.
    always_comb begin
        offset_sx  = {{8{data_bus[7]}}, data_bus};
        target     = pc_q + offset_sx;
        page_cross = (target[15:8] != pc_q[15:8]);
    end

    // Map the vector select onto a vector low-byte address; 3 aliases reset.
    always_comb begin
        sel_vec = RESET_VEC;
        case (vec_sel)
            2'd1:    sel_vec = NMI_VEC;
            2'd2:    sel_vec = IRQ_VEC;
            default: sel_vec = RESET_VEC;
        endcase
    end

    // Next-state logic: vector sequencing, then RUN priority vec_req > branch > pc_inc.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        vec_base_d = vec_base_q;
`ifdef PAGE_CROSS_PENALTY_EN
        tgt_hi_d   = tgt_hi_q;
`endif
        case (state_q)
            ST_VEC_LO: begin
                pc_d[7:0] = data_bus;
                state_d   = ST_VEC_HI;
            end
            ST_VEC_HI: begin
                pc_d[15:8] = data_bus;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (vec_req) begin
                    // PC is held so the interrupted address stays visible during entry.
                    vec_base_d = sel_vec;
                    state_d    = ST_VEC_LO;
                end else if (branch) begin
                    if (!page_cross) begin
                        pc_d = target;
                    end else begin
`ifdef PAGE_CROSS_PENALTY_EN
                        // Low byte first with the stale high byte, like the real part.
                        pc_d     = {pc_q[15:8], target[7:0]};
                        tgt_hi_d = target[15:8];
                        state_d  = ST_FIX;
`else
                        pc_d = target;
`endif
                    end
                end else if (pc_inc) begin
                    pc_d = pc_q + 16'd1;
                end
            end
            ST_FIX: begin
`ifdef PAGE_CROSS_PENALTY_EN
                pc_d[15:8] = tgt_hi_q;
`endif
                // Unreachable without the penalty; falls back to RUN if ever entered.
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_VEC_LO;
            end
        endcase
    end

    // State registers; reset restarts the reset-vector fetch from scratch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_VEC_LO;
            pc_q       <= 16'h0000;
            vec_base_q <= RESET_VEC;
`ifdef PAGE_CROSS_PENALTY_EN
            tgt_hi_q   <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            vec_base_q <= vec_base_d;
`ifdef PAGE_CROSS_PENALTY_EN
            tgt_hi_q   <= tgt_hi_d;
`endif
        end
    end

    // Fetch address and status decode, all derived from registered state.
    always_comb begin
        addr_bus = pc_q;
        case (state_q)
            ST_VEC_LO: addr_bus = vec_base_q;
            ST_VEC_HI: addr_bus = vec_base_q + 16'd1;
            default:   addr_bus = pc_q;
        endcase
        pc       = pc_q;
        vec_lo   = (state_q == ST_VEC_LO);
        pc_valid = (state_q == ST_RUN) || (state_q == ST_FIX);
`ifdef PAGE_CROSS_PENALTY_EN
        stall    = (state_q == ST_FIX);
`else
        stall    = 1'b0;
`endif
    end

endmodule
